ppg_ratio_engine: RTL and testbench

- Consumer of the LED controller's per-phase sample outputs.
- Captures one RED sample and one IR sample per LED phase and tracks min/max per channel over a window.
- At window close: derives AC (max-min) and DC ((max+min)/2) per channel, then computes the SpO2 ratio R = (AC_red*DC_ir)/(AC_ir*DC_red) in unsigned fixed point with a sequential divider.
- Sits between the LED/PGA controller and the SpO2 lookup/display logic.

---
 rtl/ppg_ratio_engine_pkg.sv | 18 +
 rtl/ppg_ratio_divider.sv | 77 +++++++
 rtl/ppg_ratio_engine.sv | 162 ++++++++++++++++
 tb/tb_ppg_ratio_engine.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_ratio_engine_pkg.sv
// Shared types and constants for the PPG ratio engine.
// Holds the state encoding, the saturation value and the default sizes.
package ppg_ratio_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ACQ  = 3'd1,
    ST_MULT = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [15:0] R_SAT      = 16'hFFFF;
  localparam int          DEF_FRAC   = 8;
  localparam int          DEF_WINDOW = 100;
  localparam int          DIV_W      = 16 + DEF_FRAC;

endpackage

// File: rtl/ppg_ratio_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, DW cycles in total.
// The first bit is resolved in the start cycle; done pulses the cycle after the last bit.
module ppg_ratio_divider
  import ppg_ratio_engine_pkg::*;
#(
  parameter int DW = DIV_W
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] dividend,
  input  logic [15:0]   divisor,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic          div_by_zero
);

  localparam int CNT_W = $clog2(DW + 1);

  logic [15:0]    rem;
  logic [15:0]    den_r;
  logic [CNT_W-1:0] cnt;
  logic           run;

  logic [15:0]    cur_rem;
  logic [DW-1:0]  cur_quo;
  logic [15:0]    cur_den;
  logic [16:0]    shifted;
  logic [16:0]    diff;
  logic           fits;
  logic [15:0]    rem_nxt;
  logic [DW-1:0]  quo_nxt;

  // The start cycle feeds the fresh operands straight into the step logic.
  assign cur_rem = start ? 16'd0   : rem;
  assign cur_quo = start ? dividend : quotient;
  assign cur_den = start ? divisor  : den_r;
  assign shifted = {cur_rem, cur_quo[DW-1]};
  assign diff    = shifted - {1'b0, cur_den};
  assign fits    = (shifted >= {1'b0, cur_den});
  assign rem_nxt = fits ? diff[15:0] : shifted[15:0];
  assign quo_nxt = {cur_quo[DW-2:0], fits};

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      rem         <= '0;
      den_r       <= '0;
      cnt         <= '0;
      run         <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        run <= 1'b0;
      end else if (start) begin
        rem         <= rem_nxt;
        quotient    <= quo_nxt;
        den_r       <= divisor;
        div_by_zero <= (divisor == 16'd0);
        cnt         <= CNT_W'(DW - 1);
        run         <= 1'b1;
      end else if (run) begin
        rem      <= rem_nxt;
        quotient <= quo_nxt;
        cnt      <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ppg_ratio_engine.sv
// Captures RED/IR samples at LED phase ends, tracks per-window min/max and
// computes the SpO2 ratio R = (AC_red*DC_ir)/(AC_ir*DC_red) in fixed point.
module ppg_ratio_engine
  import ppg_ratio_engine_pkg::*;
#(
  parameter int WINDOW = DEF_WINDOW,
  parameter int FRAC   = DEF_FRAC
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        Enable,
  input  logic        LED_RED,
  input  logic        LED_IR,
  input  logic [7:0]  RED_ADC_Value,
  input  logic [7:0]  IR_ADC_Value,
  output logic [7:0]  RED_AC,
  output logic [7:0]  RED_DC,
  output logic [7:0]  IR_AC,
  output logic [7:0]  IR_DC,
  output logic [15:0] R_Ratio,
  output logic        R_Valid,
  output logic        Error,
  output logic        Busy
);

  localparam int         DW  = 16 + FRAC;
  localparam logic [7:0] WIN = 8'(WINDOW);

  state_t state, state_nxt;

  logic       red_d, ir_d;
  logic [7:0] red_min, red_max, red_cnt;
  logic [7:0] ir_min, ir_max, ir_cnt;
  logic       red_take, ir_take;
  logic [7:0] red_min_n, red_max_n, red_cnt_n;
  logic [7:0] ir_min_n, ir_max_n, ir_cnt_n;
  logic       close;
  logic       clear;

  logic          div_start, div_abort, div_done, div_dz;
  logic [15:0]   num, den;
  logic [DW-1:0] quo;

  function automatic logic [7:0] dc_of(input logic [7:0] hi, input logic [7:0] lo);
    logic [8:0] sum;
    sum = {1'b0, hi} + {1'b0, lo};
    return sum[8:1];
  endfunction

  function automatic logic [15:0] sat_ratio(input logic [DW-1:0] q, input logic dz);
    if (dz || (q > DW'(R_SAT)))
      return R_SAT;
    return q[15:0];
  endfunction

  // Phase end = LED indicator was high last cycle and is low now.
  assign red_take = (state == ST_ACQ) && red_d && !LED_RED && (red_cnt != WIN);
  assign ir_take  = (state == ST_ACQ) && ir_d  && !LED_IR  && (ir_cnt  != WIN);

  assign red_min_n = (red_take && (RED_ADC_Value < red_min)) ? RED_ADC_Value : red_min;
  assign red_max_n = (red_take && (RED_ADC_Value > red_max)) ? RED_ADC_Value : red_max;
  assign red_cnt_n = red_cnt + {7'd0, red_take};
  assign ir_min_n  = (ir_take && (IR_ADC_Value < ir_min)) ? IR_ADC_Value : ir_min;
  assign ir_max_n  = (ir_take && (IR_ADC_Value > ir_max)) ? IR_ADC_Value : ir_max;
  assign ir_cnt_n  = ir_cnt + {7'd0, ir_take};
  assign close     = (red_cnt_n == WIN) && (ir_cnt_n == WIN);

  assign num = {8'd0, RED_AC} * {8'd0, IR_DC};
  assign den = {8'd0, IR_AC}  * {8'd0, RED_DC};

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!Enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_ACQ;
        ST_ACQ:  if (close) state_nxt = ST_MULT;
        ST_MULT: state_nxt = ST_DIV;
        ST_DIV:  if (div_done) state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_ACQ;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    Busy      = (state == ST_MULT) || (state == ST_DIV);
    div_start = Enable && (state == ST_MULT);
    div_abort = !Enable;
    clear     = !Enable || (state == ST_IDLE) || (state == ST_DONE);
  end

  ppg_ratio_divider #(.DW(DW)) u_div (
    .CLK         (CLK),
    .rst         (rst),
    .start       (div_start),
    .abort       (div_abort),
    .dividend    ({num, {FRAC{1'b0}}}),
    .divisor     (den),
    .done        (div_done),
    .quotient    (quo),
    .div_by_zero (div_dz)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      red_d   <= 1'b0;
      ir_d    <= 1'b0;
      red_min <= 8'hFF;
      red_max <= 8'h00;
      red_cnt <= 8'd0;
      ir_min  <= 8'hFF;
      ir_max  <= 8'h00;
      ir_cnt  <= 8'd0;
      RED_AC  <= 8'd0;
      RED_DC  <= 8'd0;
      IR_AC   <= 8'd0;
      IR_DC   <= 8'd0;
      R_Ratio <= 16'd0;
      R_Valid <= 1'b0;
      Error   <= 1'b0;
    end else begin
      red_d   <= LED_RED;
      ir_d    <= LED_IR;
      R_Valid <= 1'b0;
      if (clear) begin
        red_min <= 8'hFF;
        red_max <= 8'h00;
        red_cnt <= 8'd0;
        ir_min  <= 8'hFF;
        ir_max  <= 8'h00;
        ir_cnt  <= 8'd0;
      end else if (state == ST_ACQ) begin
        red_min <= red_min_n;
        red_max <= red_max_n;
        red_cnt <= red_cnt_n;
        ir_min  <= ir_min_n;
        ir_max  <= ir_max_n;
        ir_cnt  <= ir_cnt_n;
        if (close) begin
          RED_AC <= red_max_n - red_min_n;
          RED_DC <= dc_of(red_max_n, red_min_n);
          IR_AC  <= ir_max_n - ir_min_n;
          IR_DC  <= dc_of(ir_max_n, ir_min_n);
        end
      end
      // Result lands together with the DIV->DONE transition, so R_Valid is high in DONE.
      if (Enable && (state == ST_DIV) && div_done) begin
        R_Ratio <= sat_ratio(quo, div_dz);
        Error   <= div_dz;
        R_Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppg_ratio_engine.sv
// Randomized and directed bench for ppg_ratio_engine with a window-level reference model.
module tb_ppg_ratio_engine;

  localparam int WIN = 4;
  localparam int FR  = 8;

  logic        CLK = 1'b0;
  logic        rst;
  logic        Enable;
  logic        LED_RED;
  logic        LED_IR;
  logic [7:0]  RED_ADC_Value;
  logic [7:0]  IR_ADC_Value;
  logic [7:0]  RED_AC, RED_DC, IR_AC, IR_DC;
  logic [15:0] R_Ratio;
  logic        R_Valid;
  logic        Error;
  logic        Busy;

  ppg_ratio_engine #(.WINDOW(WIN), .FRAC(FR)) dut (
    .CLK           (CLK),
    .rst           (rst),
    .Enable        (Enable),
    .LED_RED       (LED_RED),
    .LED_IR        (LED_IR),
    .RED_ADC_Value (RED_ADC_Value),
    .IR_ADC_Value  (IR_ADC_Value),
    .RED_AC        (RED_AC),
    .RED_DC        (RED_DC),
    .IR_AC         (IR_AC),
    .IR_DC         (IR_DC),
    .R_Ratio       (R_Ratio),
    .R_Valid       (R_Valid),
    .Error         (Error),
    .Busy          (Busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_seen = 0;
  int rv_exp = 0;

  int rq[$];
  int iq[$];
  int e_red_ac = 0, e_red_dc = 0, e_ir_ac = 0, e_ir_dc = 0;
  int e_r = 0, e_err = 0;

  always @(negedge CLK) if (R_Valid === 1'b1) rv_seen++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Window result from the captured sample lists using the defining formulas.
  task automatic model_close();
    int rmin, rmax, imin, imax, num, den, q;
    rmin = 255; rmax = 0; imin = 255; imax = 0;
    foreach (rq[k]) begin
      if (rq[k] < rmin) rmin = rq[k];
      if (rq[k] > rmax) rmax = rq[k];
    end
    foreach (iq[k]) begin
      if (iq[k] < imin) imin = iq[k];
      if (iq[k] > imax) imax = iq[k];
    end
    e_red_ac = rmax - rmin;
    e_red_dc = (rmax + rmin) / 2;
    e_ir_ac  = imax - imin;
    e_ir_dc  = (imax + imin) / 2;
    num = e_red_ac * e_ir_dc;
    den = e_ir_ac * e_red_dc;
    if (den == 0) begin
      e_r = 65535;
      e_err = 1;
    end else begin
      q = (num * (1 << FR)) / den;
      e_r = (q > 65535) ? 65535 : q;
      e_err = 0;
    end
  endtask

  task automatic phase(input bit dr, input bit di, input int rv, input int iv, output bit closed);
    bit was_full;
    int hold;
    was_full = (rq.size() == WIN) && (iq.size() == WIN);
    hold = $urandom_range(1, 3);
    LED_RED = dr;
    LED_IR  = di;
    for (int h = 0; h < hold; h++) begin
      RED_ADC_Value = 8'($urandom);
      IR_ADC_Value  = 8'($urandom);
      tick();
    end
    LED_RED = 1'b0;
    LED_IR  = 1'b0;
    RED_ADC_Value = 8'(rv);
    IR_ADC_Value  = 8'(iv);
    if (dr && rq.size() < WIN) rq.push_back(rv);
    if (di && iq.size() < WIN) iq.push_back(iv);
    closed = !was_full && (rq.size() == WIN) && (iq.size() == WIN);
    if (closed) model_close();
    else tick();
  endtask

  task automatic finish_window();
    int lat;
    tick();
    chk("red_ac", 32'(RED_AC), e_red_ac);
    chk("red_dc", 32'(RED_DC), e_red_dc);
    chk("ir_ac", 32'(IR_AC), e_ir_ac);
    chk("ir_dc", 32'(IR_DC), e_ir_dc);
    chk("busy_compute", 32'(Busy), 1);
    lat = 1;
    while (R_Valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("latency", lat, 26);
    chk("r_ratio", 32'(R_Ratio), e_r);
    chk("error", 32'(Error), e_err);
    rv_exp++;
    tick();
    chk("rvalid_pulse", 32'(R_Valid), 0);
    rq.delete();
    iq.delete();
  endtask

  task automatic go(input bit dr, input bit di, input int rv, input int iv);
    bit c;
    phase(dr, di, rv, iv, c);
    if (c) finish_window();
  endtask

  task automatic win_both(input int r0, r1, r2, r3, i0, i1, i2, i3);
    go(1, 1, r0, i0);
    go(1, 1, r1, i1);
    go(1, 1, r2, i2);
    go(1, 1, r3, i3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_red_ac"}, 32'(RED_AC), 0);
    chk({tag, "_red_dc"}, 32'(RED_DC), 0);
    chk({tag, "_ir_ac"}, 32'(IR_AC), 0);
    chk({tag, "_ir_dc"}, 32'(IR_DC), 0);
    chk({tag, "_r"}, 32'(R_Ratio), 0);
    chk({tag, "_valid"}, 32'(R_Valid), 0);
    chk({tag, "_error"}, 32'(Error), 0);
    chk({tag, "_busy"}, 32'(Busy), 0);
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    rq.delete();
    iq.delete();
    e_red_ac = 0; e_red_dc = 0; e_ir_ac = 0; e_ir_dc = 0; e_r = 0; e_err = 0;
    tick();
  endtask

  initial begin
    bit c;
    int prev_r, prev_err, t;
    rst = 1'b1;
    Enable = 1'b0;
    LED_RED = 1'b0;
    LED_IR = 1'b0;
    RED_ADC_Value = 8'd0;
    IR_ADC_Value = 8'd0;
    tick();
    tick();
    chk_all_zero("por");
    rst = 1'b0;
    tick();
    Enable = 1'b1;
    tick();

    win_both(100, 140, 100, 140, 110, 130, 110, 130);
    chk("nominal_const", 32'(R_Ratio), 32'h0200);

    win_both(100, 140, 100, 140, 128, 128, 128, 128);
    chk("zero_den_const", 32'(Error), 1);

    win_both(0, 250, 0, 250, 254, 255, 254, 255);
    chk("sat_const", 32'(R_Ratio), 32'hFFFF);

    // Five RED phase ends before any IR; the fifth must be ignored.
    go(1, 0, 90, 0);
    go(1, 0, 120, 0);
    go(1, 0, 100, 0);
    go(1, 0, 110, 0);
    go(1, 0, 255, 0);
    go(0, 1, 0, 60);
    go(0, 1, 0, 80);
    go(0, 1, 0, 70);
    chk("no_early_close", 32'(Busy), 0);
    go(0, 1, 0, 75);

    // Abort in DIV: outputs hold, no R_Valid, fresh window afterwards.
    prev_r = e_r;
    prev_err = e_err;
    phase(1, 1, 30, 200, c);
    phase(1, 1, 90, 180, c);
    phase(1, 1, 60, 190, c);
    phase(1, 1, 40, 170, c);
    for (int k = 0; k < 10; k++) tick();
    Enable = 1'b0;
    tick();
    chk("abort_busy", 32'(Busy), 0);
    chk("abort_hold_r", 32'(R_Ratio), prev_r);
    chk("abort_red_ac", 32'(RED_AC), e_red_ac);
    e_r = prev_r;
    e_err = prev_err;
    for (int k = 0; k < 30; k++) tick();
    chk("abort_hold_r2", 32'(R_Ratio), prev_r);
    rq.delete();
    iq.delete();
    Enable = 1'b1;
    tick();
    win_both(50, 70, 60, 65, 150, 170, 160, 155);

    // Reset mid-ACQ, then mid-DIV.
    go(1, 1, 10, 20);
    go(1, 0, 30, 0);
    reset_pulse();
    phase(1, 1, 100, 120, c);
    phase(1, 1, 140, 160, c);
    phase(1, 1, 110, 130, c);
    phase(1, 1, 120, 125, c);
    for (int k = 0; k < 10; k++) tick();
    reset_pulse();
    for (int k = 0; k < 30; k++) tick();
    chk("post_reset_r", 32'(R_Ratio), 0);

    // Random windows with mixed phase types and idle gaps.
    for (int w = 0; w < 15; w++) begin
      do begin
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          RED_ADC_Value = 8'($urandom);
          IR_ADC_Value  = 8'($urandom);
          tick();
        end
        t = $urandom_range(0, 2);
        phase(t != 1, t != 0, $urandom_range(0, 255), $urandom_range(0, 255), c);
      end while (!c);
      finish_window();
    end

    chk("rvalid_count", rv_seen, rv_exp);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
